// File: rtl/dev_ram_ctrl_pkg.sv
// Shared types and quad helpers for the ULM data-RAM controller.
// Byte lanes are big-endian: offset 0 is quad[63:56].
package dev_ram_ctrl_pkg;

    localparam int SPRAM_WIDTH = 16;
    localparam int SPRAM_BANKS = 4;

    typedef enum logic [1:0] {
        RAM_NOP   = 2'd0,
        RAM_FETCH = 2'd1,
        RAM_STORE = 2'd2,
        RAM_RSVD  = 2'd3
    } ram_op_t;

    typedef enum logic [1:0] {
        RAM_BYTE = 2'd0,
        RAM_WORD = 2'd1,
        RAM_LONG = 2'd2,
        RAM_QUAD = 2'd3
    } data_type_t;

    typedef struct packed {
        logic       fetch;
        logic       err;
        logic       sext;
        data_type_t dtype;
        logic [2:0] off;
    } meta_t;

    function automatic logic [3:0] data_size(input data_type_t t);
        return 4'(4'd1 << t);
    endfunction

    // Bytes of the quad lying below the addressed field.
    function automatic logic [3:0] lead(input logic [2:0] off,
                                       input data_type_t t);
        return 4'd8 - {1'b0, off} - data_size(t);
    endfunction

    function automatic logic misaligned(input logic [2:0] off,
                                        input data_type_t t);
        logic [3:0] sz;
        logic [2:0] m;
        sz = data_size(t);
        m  = sz[2:0] - 3'd1;
        return (off & m) != 3'd0;
    endfunction

    function automatic logic [63:0] quad_lshift(input logic [63:0] w,
                                                input logic [2:0] off,
                                                input data_type_t t);
        logic [63:0] k;
        k = {64{1'b1}} >> {4'd8 - data_size(t), 3'b000};
        return (w & k) << {lead(off, t), 3'b000};
    endfunction

    function automatic logic [63:0] quad_rshift(input logic [63:0] q,
                                                input logic [2:0] off,
                                                input data_type_t t);
        return q >> {lead(off, t), 3'b000};
    endfunction

    // Nibble-granular write mask; bit j enables quad[4j+3:4j].
    function automatic logic [15:0] quad_we_mask(input logic [2:0] off,
                                                 input data_type_t t);
        logic [7:0]  bm;
        logic [15:0] m;
        bm = 8'hFF >> (4'd8 - data_size(t));
        bm = bm << lead(off, t);
        for (int j = 0; j < 8; j++) begin
            m[2*j +: 2] = {2{bm[j]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dev_ram_ctrl_if.sv
// Request/response channel between the load/store unit and the RAM controller.
// The master drives requests; the slave returns one pulse per fetch/store.
interface dev_ram_ctrl_if
    import dev_ram_ctrl_pkg::*;
#(
    parameter int ADDRW = 17
) ();

    logic             req_valid;
    logic             req_ready;
    ram_op_t          req_op;
    logic [ADDRW-1:0] req_addr;
    data_type_t       req_type;
    logic             req_sext;
    logic [63:0]      req_wdata;
    logic             rsp_valid;
    logic [63:0]      rsp_data;
    logic             rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_type, req_sext, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_type, req_sext, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/dev_ram_ctrl_sext.sv
// Fetch-path field extraction from a big-endian quad with
// zero or sign extension to 64 bits.
module dev_ram_ctrl_sext
    import dev_ram_ctrl_pkg::*;
(
    input  logic [63:0] q,
    input  data_type_t  dtype,
    input  logic        sext,
    input  logic [2:0]  off,
    output logic [63:0] d
);

    logic [63:0] f;

    always_comb begin
        f = quad_rshift(q, off, dtype);
        d = f;
        unique case (dtype)
            RAM_BYTE: d = {{56{sext & f[7]}}, f[7:0]};
            RAM_WORD: d = {{48{sext & f[15]}}, f[15:0]};
            RAM_LONG: d = {{32{sext & f[31]}}, f[31:0]};
            default:  d = f;
        endcase
    end

endmodule

// File: rtl/dev_ram_ctrl.sv
// ULM data-RAM controller: four 16-bit banks form one quad per tag,
// pipelined responses, alignment errors and a zero-sweep on reset/clear.
module dev_ram_ctrl
    import dev_ram_ctrl_pkg::*;
#(
    parameter int ADDRW          = 17,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    dev_ram_ctrl_if.slave bus,
    input  logic          clear,
    output logic          busy
);

    localparam int TAGW  = ADDRW - 3;
    localparam int DEPTH = 1 << TAGW;

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_INIT  =
        (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

    logic [1:0]      state;
    logic [TAGW-1:0] cnt;
    logic [TAGW-1:0] tag;
    logic [TAGW-1:0] wtag;
    logic [2:0]      off;
    logic            sweep;
    logic            mis;
    logic            req_ok;
    logic            inflight;
    logic [15:0]     nmask;
    logic [63:0]     wq;
    logic [63:0]     rq;
    logic [63:0]     ext;
    logic [63:0]     rd;
    meta_t           m1;
    logic            v1;
    logic            rv;
    logic            re;
    logic [63:0]     rdo;

    assign off    = bus.req_addr[2:0];
    assign tag    = bus.req_addr[ADDRW-1:3];
    assign mis    = misaligned(off, bus.req_type);
    assign sweep  = state == S_CLEAR;
    assign wtag   = sweep ? cnt : tag;
    assign req_ok = bus.req_valid && bus.req_ready &&
                    (bus.req_op == RAM_FETCH || bus.req_op == RAM_STORE);

    always_comb begin
        nmask = '0;
        wq    = '0;
        if (sweep) begin
            nmask = '1;
        end else if (req_ok && bus.req_op == RAM_STORE && !mis) begin
            nmask = quad_we_mask(off, bus.req_type);
            wq    = quad_lshift(bus.req_wdata, off, bus.req_type);
        end
    end

    // Bank 0 holds quad[63:48], bank 3 holds quad[15:0].
    for (genvar b = 0; b < SPRAM_BANKS; b++) begin : g_bank
        localparam int HI = 63 - SPRAM_WIDTH * b;
        logic [SPRAM_WIDTH-1:0] mem [DEPTH];
        logic [SPRAM_WIDTH-1:0] rdat;
        logic [3:0]             bm;
        logic [SPRAM_WIDTH-1:0] bw;

        assign bm = nmask[15 - 4*b -: 4];
        assign bw = wq[HI -: SPRAM_WIDTH];

        always_ff @(posedge clk) begin
            for (int n = 0; n < 4; n++) begin
                if (bm[n]) mem[wtag][4*n +: 4] <= bw[4*n +: 4];
            end
            rdat <= mem[tag];
        end

        assign rq[HI -: SPRAM_WIDTH] = rdat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            m1 <= '0;
        end else begin
            v1 <= req_ok;
            m1 <= '{fetch: bus.req_op == RAM_FETCH,
                    err:   mis,
                    sext:  bus.req_sext,
                    dtype: bus.req_type,
                    off:   off};
        end
    end

    dev_ram_ctrl_sext u_ext (
        .q     (rq),
        .dtype (m1.dtype),
        .sext  (m1.sext),
        .off   (m1.off),
        .d     (ext)
    );

    assign rd = (v1 && m1.fetch && !m1.err) ? ext : '0;

    if (OUT_REG != 0) begin : g_oreg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rv  <= 1'b0;
                re  <= 1'b0;
                rdo <= '0;
            end else begin
                rv  <= v1;
                re  <= v1 && m1.err;
                rdo <= rd;
            end
        end
    end else begin : g_ocomb
        assign rv  = v1;
        assign re  = v1 && m1.err;
        assign rdo = rd;
    end

    assign inflight      = v1 | rv;
    assign bus.rsp_valid = rv;
    assign bus.rsp_err   = re;
    assign bus.rsp_data  = rdo;
    assign bus.req_ready = state == S_RUN;
    assign busy          = state != S_RUN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) state <= S_RUN;
                end
                S_RUN: begin
                    if (clear) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!inflight) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dev_ram_ctrl.sv
// Scoreboard bench for dev_ram_ctrl (ADDRW=6, OUT_REG=1, sweep on reset).
// A byte-wise reference quad memory predicts every response.
module tb_dev_ram_ctrl;
    import dev_ram_ctrl_pkg::*;

    localparam int OUT_REG = 1;
    localparam int DEPTH   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;
    logic busy;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [63:0] d;
        logic        e;
        int          due;
    } exp_t;

    exp_t        sbq [$];
    logic [63:0] mdl [DEPTH];

    dev_ram_ctrl_if #(.ADDRW(6)) bus ();

    dev_ram_ctrl #(
        .ADDRW          (6),
        .OUT_REG        (OUT_REG),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .clear (clear),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_data", bus.rsp_data, e.d);
                chk("rsp_err", 64'(bus.rsp_err), 64'(e.e));
                chk("rsp_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [1:0] op, input logic [5:0] a,
                        input logic [1:0] t, input logic sx,
                        input logic [63:0] w, input bit fx = 0,
                        input logic [63:0] xd = '0);
        int n = 0;
        int sz;
        int off;
        exp_t e;
        logic [63:0] q;
        logic [63:0] v;
        bus.req_valid = 1'b1;
        bus.req_op    = ram_op_t'(op);
        bus.req_addr  = a;
        bus.req_type  = data_type_t'(t);
        bus.req_sext  = sx;
        bus.req_wdata = w;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 64'(bus.req_ready), 64'd1);
            return;
        end
        sz  = 1 << t;
        off = int'(a[2:0]);
        q   = mdl[a[5:3]];
        if (op == 2'd1 || op == 2'd2) begin
            e.e   = (off % sz) != 0;
            e.d   = '0;
            e.due = cyc + 1 + OUT_REG;
            if (!e.e && op == 2'd2) begin
                for (int i = 0; i < sz; i++)
                    q[63 - 8*(off + i) -: 8] = w[8*(sz - 1 - i) +: 8];
                mdl[a[5:3]] = q;
            end
            if (!e.e && op == 2'd1) begin
                v = '0;
                for (int i = 0; i < sz; i++)
                    v = (v << 8) | 64'(q[63 - 8*(off + i) -: 8]);
                if (sx && sz < 8 && v[8*sz - 1])
                    v = v | ~((64'd1 << (8*sz)) - 64'd1);
                e.d = v;
            end
            if (fx) e.d = xd;
            sbq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        idle();
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sbq.size()), 64'd0);
    endtask

    task automatic busy_len(output int n, output int bad);
        n   = 0;
        bad = 0;
        while (busy && n < 100) begin
            if (bus.req_ready) bad++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    initial begin : main
        int n;
        int bad;
        int r;
        logic [1:0] op;

        bus.req_valid = 1'b0;
        bus.req_op    = RAM_NOP;
        bus.req_addr  = '0;
        bus.req_type  = RAM_BYTE;
        bus.req_sext  = 1'b0;
        bus.req_wdata = '0;
        zero_model();

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", bus.rsp_data, 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);

        rst_n = 1'b1;
        busy_len(n, bad);
        chk("reset_sweep_len", 64'(n), 64'd8);
        chk("sweep_ready_low", 64'(bad), 64'd0);
        chk("ready_after_sweep", 64'(bus.req_ready), 64'd1);

        send(2'd1, 6'h38, 2'd3, 1'b0, '0, 1, 64'h0);
        send(2'd2, 6'h10, 2'd3, 1'b0, 64'h0123456789ABCDEF);
        send(2'd1, 6'h13, 2'd0, 1'b0, '0, 1, 64'h67);
        send(2'd1, 6'h16, 2'd1, 1'b1, '0, 1, 64'hFFFFFFFFFFFFCDEF);
        send(2'd2, 6'h21, 2'd0, 1'b0, 64'hAA);
        send(2'd1, 6'h20, 2'd3, 1'b0, '0, 1, 64'h00AA000000000000);
        send(2'd2, 6'h08, 2'd3, 1'b0, 64'h1122334455667788);
        send(2'd2, 6'h0A, 2'd2, 1'b0, 64'hCAFEBABE);
        send(2'd1, 6'h08, 2'd3, 1'b0, '0, 1, 64'h1122334455667788);
        wait_idle();

        send(2'd1, 6'h10, 2'd3, 1'b0, '0);
        send(2'd1, 6'h13, 2'd0, 1'b1, '0);
        send(2'd1, 6'h20, 2'd1, 1'b0, '0);
        send(2'd1, 6'h08, 2'd2, 1'b1, '0);
        wait_idle();

        for (int k = 0; k < 160; k++) begin
            r  = int'($urandom_range(0, 9));
            op = (r == 0) ? 2'd3 : (r == 1) ? 2'd0 : (r < 6) ? 2'd1 : 2'd2;
            send(op, 6'($urandom), 2'($urandom), 1'($urandom),
                 {$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) begin
                idle();
                @(negedge clk);
            end
        end
        wait_idle();

        // Fetch in flight while the clear pulse arrives.
        send(2'd1, 6'h10, 2'd3, 1'b0, '0);
        idle();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        zero_model();
        busy_len(n, bad);
        chk("clear_busy_len_ok", 64'(n >= 8 && n <= 9 + OUT_REG), 64'd1);
        chk("clear_ready_low", 64'(bad), 64'd0);
        chk("inflight_delivered", 64'(sbq.size()), 64'd0);
        chk("ready_after_clear", 64'(bus.req_ready), 64'd1);
        for (int i = 0; i < DEPTH; i++)
            send(2'd1, 6'(i * 8), 2'd3, 1'b0, '0, 1, 64'h0);
        wait_idle();

        send(2'd2, 6'h30, 2'd3, 1'b0, 64'hDEADBEEF00C0FFEE);
        wait_idle();
        send(2'd1, 6'h30, 2'd3, 1'b0, '0);
        idle();
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("flight_rsp_seen", 64'(bus.rsp_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("async_rsp_data", bus.rsp_data, 64'd0);
        chk("async_req_ready", 64'(bus.req_ready), 64'd0);
        chk("async_busy", 64'(busy), 64'd1);
        sbq.delete();
        zero_model();

        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_sweep_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_sweep_rst_ready", 64'(bus.req_ready), 64'd0);
        chk("mid_sweep_rst_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        busy_len(n, bad);
        chk("resweep_len", 64'(n), 64'd8);
        send(2'd1, 6'h30, 2'd3, 1'b0, '0, 1, 64'h0);
        send(2'd1, 6'h10, 2'd3, 1'b0, '0, 1, 64'h0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
